// File: rtl/t2s_multipass.sv
// Sequential multi-pass tree-to-sequential permutation with exact inverse.
// One pass per cycle over a working register; result is held until accepted.
module t2s_multipass #(
  parameter int WIDTH = 16,
  parameter int NUM   = 32,
  parameter int GROUP = 32,
  parameter int DW    = $clog2(NUM),
  parameter int PW    = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [NUM-1:0][WIDTH-1:0]    in_vector,
  input  logic        [DW-1:0]                in_depth,
  input  logic        [PW-1:0]                in_passes,
  input  logic                                in_inverse,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [NUM-1:0][WIDTH-1:0]    out_vector,
  output logic                                busy
);

  localparam int KW = DW + PW;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                       state_q, state_d;
  logic [NUM-1:0][WIDTH-1:0]    work_q, work_d;
  logic [DW-1:0]                depth_q, depth_d;
  logic [PW-1:0]                passes_q, passes_d;
  logic [PW-1:0]                cnt_q, cnt_d;
  logic                         inv_q, inv_d;
  logic [KW-1:0]                cur_k;
  logic [NUM-1:0][WIDTH-1:0]    pass_vec;

  // Destination of element 'pos' under the single-depth map at depth k.
  // Group and region sizes are powers of two, so masks replace modulo.
  function automatic logic [DW-1:0] map_pos(input logic [KW-1:0] k, input int pos);
    int kk, l, g, r, p, base, n;
    kk = int'(k);
    n  = pos;
    if (kk < DW) begin
      l = NUM >> kk;
      g = (GROUP < l) ? GROUP : l;
      if (g >= 4 && pos < l) begin
        r    = pos & (g - 1);
        p    = r & 1;
        base = pos - r;
        if (r < (g >> 1)) n = base + 2 * r - p;
        else              n = base + g - 1 - 2 * (r - p - (g >> 1)) - (1 - p);
      end
    end
    return DW'(n);
  endfunction

  // Inverse runs the depths top-down so that the same config round-trips.
  always_comb begin
    if (inv_q) cur_k = KW'(depth_q) + KW'(passes_q) - KW'(cnt_q) - KW'(1);
    else       cur_k = KW'(depth_q) + KW'(cnt_q);
  end

  always_comb begin
    pass_vec = work_q;
    for (int i = 0; i < NUM; i++) begin
      if (inv_q) pass_vec[i] = work_q[map_pos(cur_k, i)];
      else       pass_vec[map_pos(cur_k, i)] = work_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    depth_d  = depth_q;
    passes_d = passes_q;
    cnt_d    = cnt_q;
    inv_d    = inv_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d   = in_vector;
          depth_d  = in_depth;
          passes_d = (in_passes == '0) ? PW'(1) : in_passes;
          inv_d    = in_inverse;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        work_d = pass_vec;
        cnt_d  = cnt_q + PW'(1);
        if (cnt_q == passes_q - PW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working register doubles as the output register, so it is cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      depth_q  <= '0;
      passes_q <= '0;
      cnt_q    <= '0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      depth_q  <= depth_d;
      passes_q <= passes_d;
      cnt_q    <= cnt_d;
      inv_q    <= inv_d;
    end
  end

  assign in_ready   = (state_q == IDLE) && !rst;
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_vector = work_q;

endmodule

// File: tb/tb_t2s_multipass.sv
// Randomized self-checking bench for t2s_multipass against a direct model
// of the per-depth permutation rules.
module tb_t2s_multipass;

  localparam int WIDTH = 16;
  localparam int NUM   = 32;
  localparam int GROUP = 32;
  localparam int DW    = $clog2(NUM);
  localparam int PW    = 3;

  typedef logic signed [WIDTH-1:0] elem_t;
  typedef elem_t [NUM-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid;
  logic          in_ready;
  vec_t          in_vector;
  logic [DW-1:0] in_depth;
  logic [PW-1:0] in_passes;
  logic          in_inverse;
  logic          out_valid;
  logic          out_ready;
  vec_t          out_vector;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  t2s_multipass #(
    .WIDTH(WIDTH), .NUM(NUM), .GROUP(GROUP), .DW(DW), .PW(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vector(in_vector),
    .in_depth(in_depth), .in_passes(in_passes), .in_inverse(in_inverse),
    .out_valid(out_valid), .out_ready(out_ready), .out_vector(out_vector),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: single-depth map straight from the position rules.
  function automatic int fmap(int k, int pos, int grp);
    int l, g, r, p, base;
    if (k >= DW) return pos;
    l = NUM >> k;
    g = (grp < l) ? grp : l;
    if (g < 4 || pos >= l) return pos;
    r    = pos % g;
    p    = r % 2;
    base = pos - r;
    if (r < g / 2) return base + 2 * r - p;
    return base + g - 1 - 2 * (r - p - g / 2) - (1 - p);
  endfunction

  function automatic vec_t model(vec_t v, int d, int p, bit inv);
    vec_t cur, nx;
    int   pp;
    cur = v;
    pp  = (p == 0) ? 1 : p;
    for (int s = 0; s < pp; s++) begin
      int k;
      k = inv ? (d + pp - 1 - s) : (d + s);
      nx = cur;
      for (int i = 0; i < NUM; i++) begin
        if (inv) nx[i] = cur[fmap(k, i, GROUP)];
        else     nx[fmap(k, i, GROUP)] = cur[i];
      end
      cur = nx;
    end
    return cur;
  endfunction

  function automatic vec_t ramp();
    vec_t v;
    for (int i = 0; i < NUM; i++) v[i] = elem_t'(i);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < NUM; i++) v[i] = elem_t'($urandom);
    return v;
  endfunction

  // Present one input and complete its handshake; scramble inputs afterwards.
  task automatic send(input vec_t v, input int d, input int p, input bit inv, output bit ok);
    int waited;
    waited     = 0;
    in_vector  = v;
    in_depth   = DW'(d);
    in_passes  = PW'(p);
    in_inverse = inv;
    in_valid   = 1'b1;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    ok = in_ready;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_vector  = rand_vec();
    in_depth   = DW'($urandom);
    in_passes  = PW'($urandom);
    in_inverse = 1'($urandom);
  endtask

  task automatic wait_out(output vec_t r, output int edges, output bit ok);
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    ok = out_valid;
    r  = out_vector;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_tests++;
    if (out_vector !== vec_t'(0)) begin n_fail++; $display("FAIL rst_out_vector got %h exp 0", out_vector); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_idle got in_ready=%b busy=%b out_valid=%b exp 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_bijection();
    int grps[4];
    grps = '{4, 8, 16, 32};
    for (int gi = 0; gi < 4; gi++) begin
      int bad;
      bad = 0;
      for (int k = 0; k <= DW + PW; k++) begin
        bit seen[NUM];
        for (int i = 0; i < NUM; i++) seen[i] = 1'b0;
        for (int i = 0; i < NUM; i++) begin
          int n;
          n = fmap(k, i, grps[gi]);
          if (n < 0 || n >= NUM) bad++;
          else if (seen[n]) bad++;
          else seen[n] = 1'b1;
        end
      end
      n_tests++;
      if (bad !== 0) begin n_fail++; $display("FAIL bijection_g%0d got %0d collisions exp 0", grps[gi], bad); end
    end
  endtask

  task automatic test_fwd_d0();
    vec_t r;
    int   e;
    bit   ok1, ok2;
    int   idx[8];
    int   val[8];
    idx = '{4, 5, 8, 30, 31, 26, 0, 1};
    val = '{2, 3, 4, 16, 17, 18, 0, 1};
    send(ramp(), 0, 1, 1'b0, ok1);
    wait_out(r, e, ok2);
    n_tests++;
    if (!ok1 || !ok2 || e !== 1) begin n_fail++; $display("FAIL d0_latency got edges=%0d ok=%b%b exp 1", e, ok1, ok2); end
    for (int j = 0; j < 8; j++) begin
      n_tests++;
      if (r[idx[j]] !== elem_t'(val[j])) begin
        n_fail++;
        $display("FAIL d0_out[%0d] got %0d exp %0d", idx[j], r[idx[j]], val[j]);
      end
    end
    n_tests++;
    if (r !== model(ramp(), 0, 1, 1'b0)) begin n_fail++; $display("FAIL d0_vector got %h exp %h", r, model(ramp(), 0, 1, 1'b0)); end
    take();
  endtask

  task automatic test_fwd_d1();
    vec_t r;
    int   e, bad;
    bit   ok1, ok2;
    send(ramp(), 1, 1, 1'b0, ok1);
    wait_out(r, e, ok2);
    n_tests++;
    if (!ok1 || !ok2 || r[4] !== elem_t'(2) || r[14] !== elem_t'(8) || r[15] !== elem_t'(9)) begin
      n_fail++;
      $display("FAIL d1_spots got %0d %0d %0d exp 2 8 9", r[4], r[14], r[15]);
    end
    bad = 0;
    for (int i = 16; i < NUM; i++) if (r[i] !== elem_t'(i)) bad++;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL d1_upper_unchanged got %0d moved exp 0", bad); end
    take();
  endtask

  task automatic test_identity();
    int ds[4];
    int ps[4];
    ds = '{3, 4, 5, 31};
    ps = '{1, 1, 1, 7};
    for (int j = 0; j < 4; j++) begin
      vec_t v, r;
      int   e;
      bit   ok1, ok2;
      v = rand_vec();
      send(v, ds[j], ps[j], 1'($urandom), ok1);
      wait_out(r, e, ok2);
      n_tests++;
      if (!ok1 || !ok2 || r !== v) begin n_fail++; $display("FAIL identity_d%0d got %h exp %h", ds[j], r, v); end
      take();
    end
  endtask

  task automatic test_roundtrip();
    vec_t r, r2;
    int   e;
    bit   ok1, ok2;
    send(ramp(), 0, 3, 1'b0, ok1);
    wait_out(r, e, ok2);
    n_tests++;
    if (!ok1 || !ok2 || e !== 3) begin n_fail++; $display("FAIL rt_latency got edges=%0d exp 3", e); end
    n_tests++;
    if (r !== model(ramp(), 0, 3, 1'b0)) begin n_fail++; $display("FAIL rt_forward got %h exp %h", r, model(ramp(), 0, 3, 1'b0)); end
    take();
    send(r, 0, 3, 1'b1, ok1);
    wait_out(r2, e, ok2);
    n_tests++;
    if (!ok1 || !ok2 || r2 !== ramp()) begin n_fail++; $display("FAIL rt_inverse got %h exp %h", r2, ramp()); end
    take();
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      vec_t v, r, x;
      int   d, p, e;
      bit   inv, ok1, ok2;
      v   = rand_vec();
      d   = $urandom_range(0, NUM - 1);
      p   = $urandom_range(0, 7);
      inv = 1'($urandom);
      x   = model(v, d, p, inv);
      send(v, d, p, inv, ok1);
      wait_out(r, e, ok2);
      n_tests++;
      if (!ok1 || !ok2 || e !== ((p == 0) ? 1 : p)) begin
        n_fail++;
        $display("FAIL rand%0d_latency got %0d exp %0d", t, e, (p == 0) ? 1 : p);
      end
      n_tests++;
      if (r !== x) begin n_fail++; $display("FAIL rand%0d_vec d=%0d p=%0d inv=%b got %h exp %h", t, d, p, inv, r, x); end
      take();
    end
  endtask

  task automatic test_backpressure();
    vec_t v, r;
    int   e, bad;
    bit   ok1, ok2;
    v = rand_vec();
    send(v, 0, 2, 1'b0, ok1);
    wait_out(r, e, ok2);
    n_tests++;
    if (!ok1 || !ok2 || r !== model(v, 0, 2, 1'b0)) begin n_fail++; $display("FAIL bp_result got %h exp %h", r, model(v, 0, 2, 1'b0)); end
    in_valid  = 1'b1;
    in_vector = rand_vec();
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_vector !== r || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL bp_stable got %0d bad cycles exp 0", bad); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_before got %b exp 0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready_after got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    vec_t v, r;
    int   e, bad;
    bit   ok1, ok2;
    send(ramp(), 0, 4, 1'b0, ok1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (!ok1 || out_valid !== 1'b0 || busy !== 1'b0 || out_vector !== vec_t'(0) || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state got out_valid=%b busy=%b in_ready=%b vec=%h exp 0 0 0 0",
               out_valid, busy, in_ready, out_vector);
    end
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL midrst_no_partial got %0d bad cycles exp 0", bad); end
    v = rand_vec();
    send(v, 1, 4, 1'b1, ok1);
    wait_out(r, e, ok2);
    n_tests++;
    if (!ok1 || !ok2 || r !== model(v, 1, 4, 1'b1)) begin n_fail++; $display("FAIL midrst_next got %h exp %h", r, model(v, 1, 4, 1'b1)); end
    take();
  endtask

  initial begin
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_vector  = '0;
    in_depth   = '0;
    in_passes  = '0;
    in_inverse = 1'b0;
    test_reset();
    test_bijection();
    test_fwd_d0();
    test_fwd_d1();
    test_identity();
    test_roundtrip();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
